// File: rtl/fp_writeback_arbiter_if.sv
// Writeback request bundle between the FP result producers and the
// register-file write arbiter.
interface fp_writeback_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 5
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/fp_writeback_arbiter.sv
// Round-robin arbiter that hands the two FP register-file write ports to at most
// two producers per cycle, never two writes to the same rd, through one output stage.
module fp_writeback_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  REG_NUM = 32,
    localparam int AW      = $clog2(REG_NUM),
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    fp_writeback_arbiter_if.slave wb,
    output logic                  write_enable_1,
    output logic [AW-1:0]         write_addr_1,
    output logic [31:0]           write_data_1,
    output logic                  write_enable_2,
    output logic [AW-1:0]         write_addr_2,
    output logic [31:0]           write_data_2,
    output logic                  sb_clr_en_1,
    output logic                  sb_clr_en_2,
    output logic                  prioritize_which_port_reg,
    output logic [1:0]            grant_count
);

    logic [PW-1:0] rr_ptr;
    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [31:0]   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = wb.req_addr[i*AW +: AW];
        assign data_arr[i] = wb.req_data[i*32 +: 32];
    end

    logic          a_found, b_found;
    logic [PW-1:0] a_idx, b_idx, idx;
    logic [AW-1:0] a_addr;
    logic [PW:0]   sum;

    // Scan from rr_ptr once around: the first valid is A, the next valid with a
    // different rd is B. Same-rd requesters are passed over and retry later.
    always_comb begin
        // NOTE: every variable gets a default up front so no path can infer a latch.
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        a_addr  = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!a_found) begin
                if (wb.req_valid[idx]) begin
                    a_found = 1'b1;
                    a_idx   = idx;
                    a_addr  = addr_arr[idx];
                end
            end else if (!b_found && wb.req_valid[idx] && addr_arr[idx] != a_addr) begin
                b_found = 1'b1;
                b_idx   = idx;
            end
        end
    end

    // No grant is advertised while reset is held, so nothing handshakes into reset.
    always_comb begin
        wb.req_ready = '0;
        if (rstn) begin
            if (a_found) wb.req_ready[a_idx] = 1'b1;
            if (b_found) wb.req_ready[b_idx] = 1'b1;
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr         <= '0;
            write_enable_1 <= 1'b0;
            write_addr_1   <= '0;
            write_data_1   <= '0;
            write_enable_2 <= 1'b0;
            write_addr_2   <= '0;
            write_data_2   <= '0;
            grant_count    <= '0;
        end else begin
            write_enable_1 <= a_found;
            write_enable_2 <= b_found;
            grant_count    <= {1'b0, a_found} + {1'b0, b_found};
            if (a_found) begin
                write_addr_1 <= addr_arr[a_idx];
                write_data_1 <= data_arr[a_idx];
            end
            if (b_found) begin
                write_addr_2 <= addr_arr[b_idx];
                write_data_2 <= data_arr[b_idx];
            end
            if (b_found)
                rr_ptr <= ptr_inc(b_idx);
            else if (a_found)
                rr_ptr <= ptr_inc(a_idx);
        end
    end

    assign sb_clr_en_1               = write_enable_1;
    assign sb_clr_en_2               = write_enable_2;
    assign prioritize_which_port_reg = 1'b0;

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter: reset, single/dual grants, same-rd
// conflict, round-robin rotation and reset in the middle of a grant.
module tb_fp_writeback_arbiter;

    logic clk = 1'b0;
    logic rstn;
    logic we1, we2, sb1, sb2, prio;
    logic [4:0]  wa1, wa2;
    logic [31:0] wd1, wd2;
    logic [1:0]  gc;

    int n_cmp = 0;
    int n_bad = 0;

    fp_writeback_arbiter_if #(.NUM_REQ(4), .AW(5)) wb ();

    fp_writeback_arbiter #(.NUM_REQ(4), .REG_NUM(32)) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .wb                        (wb),
        .write_enable_1            (we1),
        .write_addr_1              (wa1),
        .write_data_1              (wd1),
        .write_enable_2            (we2),
        .write_addr_2              (wa2),
        .write_data_2              (wd2),
        .sb_clr_en_1               (sb1),
        .sb_clr_en_2               (sb2),
        .prioritize_which_port_reg (prio),
        .grant_count               (gc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, got running want finished");
        $fatal(1, "watchdog");
    end

    // {we1, sb1, addr1, data1, we2, sb2, addr2, data2, grant_count, prio}
    function automatic logic [80:0] snap();
        return {we1, sb1, wa1, wd1, we2, sb2, wa2, wd2, gc, prio};
    endfunction

    function automatic logic [80:0] ex(input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                                       input logic e2, input logic [4:0] a2, input logic [31:0] d2,
                                       input logic [1:0] g);
        return {e1, e1, a1, d1, e2, e2, a2, d2, g, 1'b0};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        wb.req_valid[i]         = v;
        wb.req_addr[i*5 +: 5]   = a;
        wb.req_data[i*32 +: 32] = d;
    endtask

    task automatic clear_all();
        wb.req_valid = '0;
        wb.req_addr  = '0;
        wb.req_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_all();
        rstn = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL do_reset_ports: got %h want %h", snap(), ex(0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(20 + i), 32'hA0 + 32'(i));
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ready: got %b want 0000", wb.req_ready);
        end
        n_cmp++;
        if (snap() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++; $display("FAIL reset_ports: got %h want %h", snap(), ex(0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0011) begin
            n_bad++; $display("FAIL reset_first_ready: got %b want 0011", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 20, 32'hA0, 1, 21, 32'hA1, 2)) begin
            n_bad++; $display("FAIL reset_first_grant: got %h want %h", snap(), ex(1, 20, 32'hA0, 1, 21, 32'hA1, 2));
        end
    endtask

    // rr_ptr is 2 on entry; port 2 still holds f21/0xA1 from the previous grant
    task automatic test_single();
        @(negedge clk);
        clear_all();
        set_req(2, 1'b1, 5'd5, 32'h3F80_0000);
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL single_ready: got %b want 0100", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 5, 32'h3F80_0000, 0, 21, 32'hA1, 1)) begin
            n_bad++; $display("FAIL single_ports: got %h want %h", snap(), ex(1, 5, 32'h3F80_0000, 0, 21, 32'hA1, 1));
        end
    endtask

    // rr_ptr is 0 on entry
    task automatic test_dual();
        @(negedge clk);
        clear_all();
        set_req(1, 1'b1, 5'd3, 32'h4000_0000);
        set_req(3, 1'b1, 5'd7, 32'h4040_0000);
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b1010) begin
            n_bad++; $display("FAIL dual_ready: got %b want 1010", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 3, 32'h4000_0000, 1, 7, 32'h4040_0000, 2)) begin
            n_bad++; $display("FAIL dual_ports: got %h want %h", snap(), ex(1, 3, 32'h4000_0000, 1, 7, 32'h4040_0000, 2));
        end
        // idle cycle: enables drop, addr/data hold
        @(negedge clk);
        clear_all();
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(0, 3, 32'h4000_0000, 0, 7, 32'h4040_0000, 0)) begin
            n_bad++; $display("FAIL idle_hold: got %h want %h", snap(), ex(0, 3, 32'h4000_0000, 0, 7, 32'h4040_0000, 0));
        end
        // rr_ptr wrapped to 0: requester 0 wins port 1 over requester 3
        @(negedge clk);
        set_req(0, 1'b1, 5'd11, 32'h4100_0000);
        set_req(3, 1'b1, 5'd12, 32'h4110_0000);
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b1001) begin
            n_bad++; $display("FAIL wrap_ready: got %b want 1001", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 11, 32'h4100_0000, 1, 12, 32'h4110_0000, 2)) begin
            n_bad++; $display("FAIL wrap_ports: got %h want %h", snap(), ex(1, 11, 32'h4100_0000, 1, 12, 32'h4110_0000, 2));
        end
    endtask

    // rr_ptr is 0 on entry; port 2 holds f12/0x41100000
    task automatic test_conflict();
        @(negedge clk);
        clear_all();
        set_req(0, 1'b1, 5'd9, 32'h4120_0000);
        set_req(1, 1'b1, 5'd9, 32'h4130_0000);
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL conflict_ready1: got %b want 0001", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 9, 32'h4120_0000, 0, 12, 32'h4110_0000, 1)) begin
            n_bad++; $display("FAIL conflict_ports1: got %h want %h", snap(), ex(1, 9, 32'h4120_0000, 0, 12, 32'h4110_0000, 1));
        end
        @(negedge clk);
        wb.req_valid[0] = 1'b0;
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL conflict_ready2: got %b want 0010", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 9, 32'h4130_0000, 0, 12, 32'h4110_0000, 1)) begin
            n_bad++; $display("FAIL conflict_ports2: got %h want %h", snap(), ex(1, 9, 32'h4130_0000, 0, 12, 32'h4110_0000, 1));
        end
    endtask

    // rr_ptr is 0 on entry; grants alternate (0,1), (2,3)
    task automatic test_back_to_back();
        logic [3:0]  rdy_exp;
        logic [80:0] port_exp;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 1), 32'h3000_0000 + 32'(i));
        for (int c = 0; c < 4; c++) begin
            if (c % 2 == 0) begin
                rdy_exp  = 4'b0011;
                port_exp = ex(1, 1, 32'h3000_0000, 1, 2, 32'h3000_0001, 2);
            end else begin
                rdy_exp  = 4'b1100;
                port_exp = ex(1, 3, 32'h3000_0002, 1, 4, 32'h3000_0003, 2);
            end
            #1;
            n_cmp++;
            if (wb.req_ready !== rdy_exp) begin
                n_bad++; $display("FAIL rotate_ready[%0d]: got %b want %b", c, wb.req_ready, rdy_exp);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (snap() !== port_exp) begin
                n_bad++; $display("FAIL rotate_ports[%0d]: got %h want %h", c, snap(), port_exp);
            end
            @(negedge clk);
        end
    endtask

    // rr_ptr is 0 on entry
    task automatic test_reset_mid();
        clear_all();
        set_req(2, 1'b1, 5'd6, 32'h40A0_0000);
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL mid_ready_pre: got %b want 0100", wb.req_ready);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_ready_rst: got %b want 0000", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++; $display("FAIL mid_ports: got %h want %h", snap(), ex(0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rstn = 1'b1;
        clear_all();
        set_req(0, 1'b1, 5'd13, 32'h4150_0000);
        set_req(3, 1'b1, 5'd14, 32'h4160_0000);
        #1;
        n_cmp++;
        if (wb.req_ready !== 4'b1001) begin
            n_bad++; $display("FAIL mid_after_ready: got %b want 1001", wb.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (snap() !== ex(1, 13, 32'h4150_0000, 1, 14, 32'h4160_0000, 2)) begin
            n_bad++; $display("FAIL mid_after_ports: got %h want %h", snap(), ex(1, 13, 32'h4150_0000, 1, 14, 32'h4160_0000, 2));
        end
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single();
        do_reset();
        test_dual();
        test_conflict();
        do_reset();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        clear_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_writeback_arbiter.md
Name: fp_writeback_arbiter

Overview:
- Shares the two FP register-file write ports among NUM_REQ result producers (FADD/FMUL pipes, FDIV/FSQRT unit, FLW load return, int-to-FP move).
- Each producer offers a valid/ready writeback carrying destination rd and a 32-bit result.
- Grants at most two producers per cycle, round-robin, and never grants two writes to the same rd in one cycle.
- Registers the granted writes into a one-cycle output stage that drives the register-file write ports and the matching scoreboard-clear (busy=0) strobes.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- REG_NUM, 32, number of FP registers; address width AW = $clog2(REG_NUM).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester writeback valid.
- req_ready  out  NUM_REQ  per-requester grant; combinational from req_valid, req_addr and rr_ptr.
- req_addr  in  NUM_REQ*AW  per-requester rd; slice i = [i*AW +: AW].
- req_data  in  NUM_REQ*32  per-requester result; slice i = [i*32 +: 32].
- write_enable_1  out  1  register-file port 1 write enable (registered).
- write_addr_1  out  AW  port 1 address (registered).
- write_data_1  out  32  port 1 data (registered).
- write_enable_2  out  1  register-file port 2 write enable (registered).
- write_addr_2  out  AW  port 2 address (registered).
- write_data_2  out  32  port 2 data (registered).
- sb_clr_en_1  out  1  scoreboard clear for write_addr_1; equals write_enable_1.
- sb_clr_en_2  out  1  scoreboard clear for write_addr_2; equals write_enable_2.
- prioritize_which_port_reg  out  1  constant 0; same-address dual writes never occur.
- grant_count  out  2  writes issued this cycle (0..2), registered, for perf counters.

Behaviour:
- State:
  - rr_ptr, $clog2(NUM_REQ) bits, reset 0.
  - Output stage registers.
- Reset: rr_ptr=0; write_enable_1/2=0; addr/data=0; grant_count=0. req_ready is 0 during reset.
- Grant A (combinational):
  - Scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant A is the first i with req_valid[i]=1.
- Grant B (combinational):
  - Continue the scan after A, wrapping, stopping before returning to rr_ptr.
  - Grant B is the first j != A with req_valid[j]=1 and req_addr[j] != req_addr[A].
  - Requesters skipped for an address match with A keep req_valid high and are not granted this cycle.
- Readiness and handshake:
  - req_ready[k]=1 only for k in {A, B}.
  - A handshake completes when valid&ready are both high at the clock edge.
  - A requester must hold addr/data stable while valid=1 and ready=0. Valid may not drop before the grant.
- Output stage (next edge):
  - write_enable_1 <= (A exists); write_addr_1/write_data_1 <= A's addr/data.
  - write_enable_2 <= (B exists); port 2 gets B's addr/data.
  - B is never loaded without A.
  - Addr/data registers hold their previous value when the corresponding enable is 0.
- Latency: the register write and scoreboard clear are seen by the register file one cycle after the handshake.
- Pointer update:
  - If B exists: rr_ptr <= (B+1) mod NUM_REQ.
  - Else if A exists: rr_ptr <= (A+1) mod NUM_REQ.
  - Else: unchanged.
- Fairness: every continuously valid requester is granted within NUM_REQ-1 cycles, including one blocked by same-address conflict. The wrap of rr_ptr past NUM_REQ-1 goes to 0.
- No buffering beyond the output stage; no backpressure from the register file (always accepts).
- Reset mid-operation:
  - Granted but not-yet-registered writes are discarded.
  - Write enables are 0 in the cycle after rstn is sampled low.
  - Scoreboard contents are reset by the register file itself.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with all req_valid=1 -> req_ready=0, write_enable_1/2=0, grant_count=0; after release, first grants are A=0, B=1.
- Single request: only req_valid[2]=1, addr=5, data=0x3F800000 -> req_ready=4'b0100; next cycle write_enable_1=1, addr 5, data 0x3F800000, write_enable_2=0, sb_clr_en_1=1; rr_ptr=3.
- Dual grant: req 1 (addr 3, 0x40000000) and req 3 (addr 7, 0x40400000), rr_ptr=0 -> ready=4'b1010; next cycle port1 = f3/0x40000000, port2 = f7/0x40400000, grant_count=2; rr_ptr wraps to 0.
- Same-rd conflict: req 0 and req 1 both addr 9, rr_ptr=0 -> cycle 1 grants only 0 (port1, f9); cycle 2 grants 1 on port1, write_enable_2=0; prioritize_which_port_reg stays 0.
- Fairness/rotation: all four valid continuously with distinct addrs -> grant pairs (0,1), (2,3), (0,1)...; no requester waits more than 1 cycle.
- Reset mid-operation: assert rstn=0 on the cycle requester 2 is granted -> no write appears on either port; rr_ptr=0 after reset.
